md_unit: RTL

- Multi-cycle multiply/divide unit with architectural HI/LO registers; executes mult, multu, div, divu, mthi, mtlo.
- Operands come from the register-file read ports: A from the first read port (rs), B from the second (rt).
- HI/LO drive the register-file write-data mux for mfhi/mflo.
- Busy goes to the controller, which stalls any md instruction while Start|Busy.

---
 rtl/md_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit -- multi-cycle multiply/divide unit holding the architectural HI/LO
// registers. Executes mult, multu, div, divu (multi-cycle, result committed
// to HI/LO when the cycle counter expires) and mthi/mtlo (single edge).
//
// Ports:
//   clk    in   1   system clock, rising-edge
//   Reset  in   1   synchronous, active-high reset
//   Start  in   1   launch the operation selected by MDOp
//   MDOp   in   3   0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6/7=no-op
//   A      in  32   rs operand (multiplicand / dividend / mthi-mtlo source)
//   B      in  32   rt operand (multiplier / divisor)
//   Busy   out  1   operation in progress (registered)
//   HI     out 32   HI register
//   LO     out 32   LO register
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NOP6  = 3'd6,
        OP_NOP7  = 3'd7
    } md_op_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_op_e op;
    assign op = md_op_e'(MDOp);

    // ------------------------------------------------------------------
    // Arithmetic datapath (evaluated on the Start edge only)
    // ------------------------------------------------------------------
    logic        is_signed;
    logic [63:0] a_ext, b_ext, product;
    logic [31:0] dividend, divisor, divisor_safe;
    logic [31:0] quot_mag, rem_mag, quot, rem;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);

    // Sign-extending to 64 bits makes the low 64 bits of an unsigned
    // multiply equal to the signed product, so one multiplier serves both.
    assign a_ext   = is_signed ? {{32{A[31]}}, A} : {32'd0, A};
    assign b_ext   = is_signed ? {{32{B[31]}}, B} : {32'd0, B};
    assign product = a_ext * b_ext;

    // Signed division is done on magnitudes and the signs fixed up after:
    // quotient truncates toward zero, remainder follows the dividend.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, rem 0.
    assign dividend     = (is_signed && A[31]) ? (32'd0 - A) : A;
    assign divisor      = (is_signed && B[31]) ? (32'd0 - B) : B;
    assign divisor_safe = (divisor == 32'd0) ? 32'd1 : divisor;
    assign quot_mag     = dividend / divisor_safe;
    assign rem_mag      = dividend % divisor_safe;
    assign quot         = (is_signed && (A[31] ^ B[31])) ? (32'd0 - quot_mag) : quot_mag;
    assign rem          = (is_signed && A[31]) ? (32'd0 - rem_mag) : rem_mag;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_we_q, pend_we_d;   // low for divide-by-zero: commit is suppressed
    logic             busy_q, busy_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        if (cnt_q == '0) begin
            // IDLE: Start is only honoured here.
            if (Start) begin
                unique case (op)
                    OP_MULT, OP_MULTU: begin
                        pend_hi_d = product[63:32];
                        pend_lo_d = product[31:0];
                        pend_we_d = 1'b1;
                        cnt_d     = CNT_W'(MULT_CYCLES);
                    end
                    OP_DIV, OP_DIVU: begin
                        pend_hi_d = rem;
                        pend_lo_d = quot;
                        pend_we_d = (B != 32'd0);
                        cnt_d     = CNT_W'(DIV_CYCLES);
                    end
                    OP_MTHI: hi_d = A;
                    OP_MTLO: lo_d = A;
                    default: ;
                endcase
            end
        end else begin
            // RUN: count down, commit on the 1 -> 0 transition.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) && pend_we_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (Reset) begin
            // Pending registers are cleared too; an aborted operation must
            // leave nothing behind that a later commit could pick up.
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
            busy_q    <= busy_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
